dmem_responder: RTL
===================

# dmem_responder

Word-addressed data-memory responder that answers load/store requests from the MIPS core's data-memory port over a request/ready handshake. It inserts a configurable number of wait states, so a multi-cycle or stalling core can run against a slow memory model. It also flags misaligned and out-of-range accesses. It sits between the core's ALU-result/ReadData2 outputs and the MemtoReg write-back mux, in place of a zero-latency combinational memory.

## Interface
- DEPTH_WORDS, 64: number of 32-bit words; valid byte addresses are 0 .. 4*DEPTH_WORDS-1.
- WAIT_STATES, 2: extra cycles between request acceptance and completion; legal range 0..15.

- clock  input  1  single clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low; 0 forces reset state immediately.
- req  input  1  access request; sampled only in IDLE.
- we  input  1  1 = store, 0 = load; sampled with req.
- addr  input  32  byte address; sampled with req.
- wdata  input  32  store data; sampled with req.
- rdata  output  32  load data; registered.
- ready  output  1  one-cycle completion pulse; registered.
- err  output  1  error status of the access completing this cycle; valid only while ready=1.
- busy  output  1  1 while an accepted access is outstanding (state BUSY).

## Operation
- State machine: IDLE, BUSY. Counter cnt is 4 bits wide.
- IDLE with req=1 at an edge:
  - latch addr, we and wdata;
  - set cnt to WAIT_STATES;
  - go to BUSY.
- IDLE with req=0: stay in IDLE.
- BUSY with cnt>0: decrement cnt. Inputs are ignored.
- BUSY with cnt==0, at the next edge:
  - perform the access;
  - set ready to 1 for exactly one cycle;
  - go to IDLE.
- Address check on the latched address:
  - misaligned = addr[1:0] != 0;
  - out-of-range = addr[31:2] >= DEPTH_WORDS;
  - either condition means error.
- Completion, good load: rdata gets mem[addr[31:2]]; err = 0.
- Completion, good store: mem[addr[31:2]] gets wdata; rdata holds its previous value; err = 0.
- Completion, error: memory is not modified; rdata = 0; err = 1.
- req, we, addr and wdata do not need to be held after acceptance.
- req is ignored while busy = 1.
- busy = (state == BUSY); it is decoded from the state register only.
- ready is 0 in every cycle except the completion cycle.
- err is cleared to 0 on any edge that does not complete an access.

## Timing
- Reset (reset=0, asynchronous) forces:
  - state = IDLE, cnt = 0;
  - ready = 0, err = 0, rdata = 0, busy = 0;
  - all memory words = 0.
- Release of reset is synchronous to the next rising edge.
- Latency: if req is accepted at edge k, ready is high in the cycle after edge k+WAIT_STATES+1.
  - WAIT_STATES = 0: ready follows acceptance by exactly one edge.
- ready is low while the design is in IDLE on the accepting edge. A req asserted in the cycle where ready=1 is accepted at the following edge.
- With req held at 1 continuously, accesses repeat every WAIT_STATES+2 cycles.
- Store visibility: a load accepted after a store's ready pulse returns the stored value.
- Reset asserted mid-access:
  - the access is abandoned;
  - no write commits, even if the assertion coincides with the completion edge;
  - no ready pulse is produced.
- No combinational path exists from any input to any output.

## Test plan
- Reset then idle: assert reset=0 mid-cycle, release, keep req=0 for 10 cycles -> rdata=0, ready=0, err=0 and busy=0 throughout. busy and ready drop immediately on reset assertion.
- Store/load, WAIT_STATES=2:
  - store addr=0x10, wdata=0xDEADBEEF accepted at edge k -> busy high for 3 cycles, single ready pulse after edge k+3, err=0, rdata unchanged;
  - then load addr=0x10 -> rdata=0xDEADBEEF with ready.
- Errors:
  - load addr=0x12 -> ready with err=1 and rdata=0;
  - store addr=0x100 (word 64, DEPTH_WORDS=64) with wdata=0x1 -> err=1;
  - a later load of every word 0..63 returns its prior contents, so no word was corrupted.
- Request during busy: toggle req with addr=0x4 while busy=1 -> ignored; exactly one ready pulse, for the original address only.
- Continuous req=1, WAIT_STATES=0, loads of addr=0x8 holding 0x12345678 -> ready pulses every 2 cycles, rdata=0x12345678 each time.
- Reset at completion: store 0x20 <- 0xCAFEF00D; assert reset coincident with the completion edge; release; load 0x20 -> rdata=0, and no ready pulse for the aborted store.

Source files
------------

// File: rtl/dmem_responder.sv
// Word-addressed data memory that answers core load/store requests after a
// fixed number of wait states, flagging misaligned and out-of-range accesses.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err,
  output logic        busy
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [3:0]  cnt;
  logic [3:0]  cnt_next;
  logic        accept;
  logic        complete;

  logic        we_p0;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic        bad_p0;
  logic [IDX_W-1:0] idx_p0;

  logic [31:0] mem [DEPTH_WORDS];

  function automatic logic access_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= DEPTH_LIM);
  endfunction

  assign busy   = (state == BUSY);
  assign bad_p0 = access_bad(addr_p0);
  assign idx_p0 = addr_p0[IDX_W+1:2];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept     = 1'b1;
          cnt_next   = WAIT_INIT;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (cnt != 4'd0) begin
          cnt_next = cnt - 4'd1;
        end else begin
          complete   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: request captured on acceptance so the core need not hold it.
  always_ff @(posedge clock) begin
    if (accept) begin
      we_p0    <= we;
      addr_p0  <= addr;
      wdata_p0 <= wdata;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem[i] <= 32'd0;
      end
    end else if (complete && we_p0 && !bad_p0) begin
      mem[idx_p0] <= wdata_p0;
    end
  end

  // Stage p1: completion response; rdata keeps its value across good stores.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata <= 32'd0;
      ready <= 1'b0;
      err   <= 1'b0;
    end else begin
      ready <= complete;
      err   <= complete && bad_p0;
      if (complete) begin
        if (bad_p0) begin
          rdata <= 32'd0;
        end else if (!we_p0) begin
          rdata <= mem[idx_p0];
        end
      end
    end
  end

endmodule
